// File: rtl/pong_ball_ctrl_if.sv
// Pong ball controller bundle: game inputs toward the sequencer, ball/status toward display.
// Latency: wires only; every output carried here is registered inside the sequencer.
// Backpressure: none; pause is the only stall input and it freezes the sequencer in place.
interface pong_ball_ctrl_if;
  logic       start;
  logic       pause;
  logic [2:0] paddle_x;
  logic [2:0] ball_x;
  logic [2:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic       busy;
  logic       endgame;
  logic [3:0] hits;
  logic       step;

  // Game-side driver: owns start/pause/paddle, observes ball and status.
  modport master (
    output start, pause, paddle_x,
    input  ball_x, ball_y, dir_x, dir_y, busy, endgame, hits, step
  );

  // Sequencer side.
  modport slave (
    input  start, pause, paddle_x,
    output ball_x, ball_y, dir_x, dir_y, busy, endgame, hits, step
  );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Pong ball sequencer: moves the ball one cell per TICK_DIV cycles, bounces, counts returns, detects miss.
// Latency: first step TICK_DIV edges after start is sampled; all outputs registered, step pulses the cycle after.
// Backpressure: pause freezes tick counter and ball; a step due on a paused cycle slips to the first unpaused one.
module pong_ball_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned SERVE_X  = 3,
  parameter int unsigned SERVE_Y  = 1
) (
  input logic             clk,
  input logic             rst_n,
  pong_ball_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [7:0] TC      = 8'(TICK_DIV - 1);
  localparam logic [2:0] SRV_X   = 3'(SERVE_X);
  localparam logic [2:0] SRV_Y   = 3'(SERVE_Y);
  localparam logic [2:0] TOP_ROW = 3'd1;
  localparam logic [2:0] PAD_ROW = 3'd6;
  localparam logic [2:0] MISS_ROW = 3'd7;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] x_q, x_d;
  logic [2:0] y_q, y_d;
  logic       dx_q, dx_d;
  logic       dy_q, dy_d;
  logic [3:0] hits_q, hits_d;
  logic       step_q, step_d;

  logic       ndx, ndy;
  logic       tc;
  logic       hit;
  logic [3:0] pad_lo, pad_hi, x_ext;

  // Paddle span is compared in 4 bits so paddle_x = 7 covers only column 7 (no wrap to 0).
  assign pad_lo = {1'b0, bus.paddle_x};
  assign pad_hi = pad_lo + 4'd1;
  assign x_ext  = {1'b0, x_q};
  assign hit    = (y_q == PAD_ROW) && (x_ext >= pad_lo) && (x_ext <= pad_hi);
  assign tc     = (cnt_q == TC);

  // Bounce rules: side walls force x direction, top wall forces down, paddle hit on row 6 forces up.
  always_comb begin
    ndx = dx_q;
    ndy = dy_q;
    if (x_q == 3'd1) begin
      ndx = 1'b0;
    end else if (x_q == 3'd6) begin
      ndx = 1'b1;
    end
    if (y_q == TOP_ROW) begin
      ndy = 1'b0;
    end else if (hit) begin
      ndy = 1'b1;
    end
  end

  // Next-state and datapath: serve on start, step on unpaused terminal count, stop on the miss row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    hits_d  = hits_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (state_q == IDLE) begin
          x_d = SRV_X;
          y_d = SRV_Y;
        end
        if (bus.start) begin
          state_d = RUN;
          x_d     = SRV_X;
          y_d     = SRV_Y;
          dx_d    = 1'b0;
          dy_d    = 1'b0;
          hits_d  = 4'd0;
          cnt_d   = 8'd0;
        end
      end
      RUN: begin
        if (!bus.pause) begin
          if (tc) begin
            cnt_d  = 8'd0;
            step_d = 1'b1;
            if (y_q == MISS_ROW) begin
              // Ball already fell past the paddle: freeze everything and end the game.
              state_d = OVER;
            end else begin
              dx_d = ndx;
              dy_d = ndy;
              x_d  = ndx ? (x_q - 3'd1) : (x_q + 3'd1);
              y_d  = ndy ? (y_q - 3'd1) : (y_q + 3'd1);
              if (hit && (hits_q != 4'd15)) begin
                hits_d = hits_q + 4'd1;
              end
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset parks the ball at the serve cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      x_q     <= SRV_X;
      y_q     <= SRV_Y;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      hits_q  <= 4'd0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      hits_q  <= hits_d;
      step_q  <= step_d;
    end
  end

  assign bus.ball_x  = x_q;
  assign bus.ball_y  = y_q;
  assign bus.dir_x   = dx_q;
  assign bus.dir_y   = dy_q;
  assign bus.hits    = hits_q;
  assign bus.step    = step_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.endgame = (state_q == OVER);

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl with TICK_DIV=4, SERVE_X=3, SERVE_Y=1.
// Latency: waits for each step pulse within a bounded cycle budget and checks the spacing.
// Backpressure: exercises pause mid-count and on the terminal count.
module tb_pong_ball_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  pong_ball_ctrl_if bus ();

  pong_ball_ctrl #(.TICK_DIV(4), .SERVE_X(3), .SERVE_Y(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Ball path repeats every 10 steps once the first return has happened (from step 6 on).
  int tx  [10] = '{3, 2, 1, 2, 3, 4, 5, 6, 5, 4};
  int ty  [10] = '{5, 4, 3, 2, 1, 2, 3, 4, 5, 6};
  int tdx [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
  int tdy [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ball(input string tag, input int ex, input int ey, input int edx,
                          input int edy, input int eh);
    chk({tag, ".x"}, 32'(bus.ball_x), ex);
    chk({tag, ".y"}, 32'(bus.ball_y), ey);
    chk({tag, ".dx"}, 32'(bus.dir_x), edx);
    chk({tag, ".dy"}, 32'(bus.dir_y), edy);
    chk({tag, ".hits"}, 32'(bus.hits), eh);
  endtask

  // Waits for the next step pulse (bounded) and checks its spacing plus the new ball state.
  task automatic step_chk(input string tag, input int exp_n, input int ex, input int ey,
                          input int edx, input int edy, input int eh);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.step !== 1'b1 && n < 64);
    chk({tag, ".lat"}, n, exp_n);
    chk_ball(tag, ex, ey, edx, edy, eh);
  endtask

  task automatic serve();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    chk("serve.busy", 32'(bus.busy), 1);
    chk("serve.end", 32'(bus.endgame), 0);
    chk_ball("serve", 3, 1, 0, 0, 0);
  endtask

  // Steps 1..5 of every game from the default serve, with no paddle contact yet.
  task automatic opening(input string g);
    step_chk({g, "1"}, 4, 4, 2, 0, 0, 0);
    step_chk({g, "2"}, 4, 5, 3, 0, 0, 0);
    step_chk({g, "3"}, 4, 6, 4, 0, 0, 0);
    step_chk({g, "4"}, 4, 5, 5, 1, 0, 0);
    step_chk({g, "5"}, 4, 4, 6, 1, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int eh;
    int idx;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.paddle_x = 3'd3;
    rst_n        = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk_ball("rst", 3, 1, 0, 0, 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.end", 32'(bus.endgame), 0);
    chk("rst.step", 32'(bus.step), 0);
    tick(2);
    rst_n = 1'b1;

    // IDLE holds the serve position with no steps.
    tick(6);
    chk("idle.step", 32'(bus.step), 0);
    chk("idle.busy", 32'(bus.busy), 0);
    chk_ball("idle", 3, 1, 0, 0, 0);

    // Game A: serve walk with pause, then 16+ returns alternating paddle edges, then a miss.
    serve();
    step_chk("a1", 4, 4, 2, 0, 0, 0);
    tick(2);
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("pause.step", 32'(bus.step), 0);
      chk("pause.x", 32'(bus.ball_x), 4);
    end
    bus.pause = 1'b0;
    step_chk("a2", 2, 5, 3, 0, 0, 0);
    tick(3);
    bus.pause = 1'b1;
    tick(1);
    chk("tcpause.step", 32'(bus.step), 0);
    chk("tcpause.y", 32'(bus.ball_y), 3);
    bus.pause = 1'b0;
    step_chk("a3", 1, 6, 4, 0, 0, 0);
    step_chk("a4", 4, 5, 5, 1, 0, 0);
    step_chk("a5", 4, 4, 6, 1, 0, 0);
    // Ball at x=4: paddle_x=3 catches it on the right cell, paddle_x=4 on the left cell.
    step_chk("a6", 4, 3, 5, 1, 1, 1);
    for (int s = 7; s <= 165; s++) begin
      idx = (s - 6) % 10;
      eh  = 1 + (s - 6) / 10;
      if (eh > 15) eh = 15;
      bus.paddle_x = ((((s - 6) / 10) % 2) != 0) ? 3'd4 : 3'd3;
      step_chk($sformatf("a%0d", s), 4, tx[idx], ty[idx], tdx[idx], tdy[idx], eh);
    end
    bus.paddle_x = 3'd0;
    step_chk("a166", 4, 3, 7, 1, 0, 15);
    step_chk("a167", 4, 3, 7, 1, 0, 15);
    chk("over.end", 32'(bus.endgame), 1);
    chk("over.busy", 32'(bus.busy), 0);
    tick(1);
    chk("over.step1", 32'(bus.step), 0);
    tick(8);
    chk("over.step2", 32'(bus.step), 0);
    chk_ball("over.hold", 3, 7, 1, 0, 15);

    // Game B: restart from OVER, start ignored in RUN, paddle_x=5 misses x=4.
    bus.paddle_x = 3'd5;
    serve();
    step_chk("b1", 4, 4, 2, 0, 0, 0);
    bus.start = 1'b1;
    tick(2);
    bus.start = 1'b0;
    step_chk("b2", 2, 5, 3, 0, 0, 0);
    step_chk("b3", 4, 6, 4, 0, 0, 0);
    step_chk("b4", 4, 5, 5, 1, 0, 0);
    step_chk("b5", 4, 4, 6, 1, 0, 0);
    step_chk("b6", 4, 3, 7, 1, 0, 0);
    step_chk("b7", 4, 3, 7, 1, 0, 0);
    chk("b.end", 32'(bus.endgame), 1);

    // Game C: paddle_x=2 covers columns 2..3 and misses x=4.
    bus.paddle_x = 3'd2;
    serve();
    opening("c");
    step_chk("c6", 4, 3, 7, 1, 0, 0);
    step_chk("c7", 4, 3, 7, 1, 0, 0);
    chk("c.end", 32'(bus.endgame), 1);
    chk("c.busy", 32'(bus.busy), 0);

    // Game D: asynchronous reset between clock edges mid-RUN.
    bus.paddle_x = 3'd3;
    serve();
    step_chk("d1", 4, 4, 2, 0, 0, 0);
    step_chk("d2", 4, 5, 3, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk_ball("arst", 3, 1, 0, 0, 0);
    chk("arst.busy", 32'(bus.busy), 0);
    chk("arst.end", 32'(bus.endgame), 0);
    chk("arst.step", 32'(bus.step), 0);
    #2 rst_n = 1'b1;
    tick(6);
    chk("post.busy", 32'(bus.busy), 0);
    chk("post.step", 32'(bus.step), 0);
    chk_ball("post", 3, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
